// File: rtl/iq_power_detector.sv
// rtl/iq_power_detector.sv - windowed |x|^2 energy detector with block and sliding modes
module iq_power_detector #(
    parameter int  DATA_W   = 8,
    parameter int  WIN_LOG2 = 4,
    localparam int MAG_W    = 2 * DATA_W,
    localparam int ACC_W    = MAG_W + WIN_LOG2
) (
    input  logic                     clk,
    input  logic                     aclr_n,
    input  logic                     sclr,
    input  logic                     mode,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] datar,
    input  logic signed [DATA_W-1:0] datai,
    input  logic [ACC_W-1:0]         threshold,
    output logic                     out_valid,
    output logic [ACC_W-1:0]         energy,
    output logic                     detect,
    output logic [7:0]               detect_cnt
);

    localparam int N = 1 << WIN_LOG2;

    typedef enum logic {FILL, RUN} state_t;

    state_t state, state_next;

    logic mode_q, mode_d, clr;

    logic signed [DATA_W-1:0] re0, im0;
    logic                     v0;
    logic signed [MAG_W-1:0]  re_ext, im_ext;
    logic [MAG_W-1:0]         sq_re, sq_im;
    logic                     v1;
    logic [MAG_W-1:0]         mag;
    logic                     v2;

    logic [ACC_W-1:0]    acc, acc_next, sum, oldest, energy_next;
    logic [WIN_LOG2-1:0] fill_cnt, fill_next, wptr;
    logic                emit;
    logic [MAG_W-1:0]    mag_buf [N];

    // A change of the registered mode clears everything one cycle later,
    // so no window ever mixes samples from both modes.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            mode_q <= 1'b0;
            mode_d <= 1'b0;
        end else begin
            mode_q <= mode;
            mode_d <= mode_q;
        end
    end

    assign clr = sclr | (mode_q != mode_d);

    assign re_ext = MAG_W'(re0);
    assign im_ext = MAG_W'(im0);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            re0   <= '0;
            im0   <= '0;
            v0    <= 1'b0;
            sq_re <= '0;
            sq_im <= '0;
            v1    <= 1'b0;
            mag   <= '0;
            v2    <= 1'b0;
        end else if (clr) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v0 <= in_valid;
            if (in_valid) begin
                re0 <= datar;
                im0 <= datai;
            end
            v1 <= v0;
            if (v0) begin
                sq_re <= $unsigned(re_ext * re_ext);
                sq_im <= $unsigned(im_ext * im_ext);
            end
            v2 <= v1;
            if (v1) begin
                mag <= sq_re + sq_im;
            end
        end
    end

    always_comb begin
        state_next  = state;
        acc_next    = acc;
        fill_next   = fill_cnt;
        emit        = 1'b0;
        oldest      = ACC_W'(mag_buf[wptr]);
        sum         = acc + ACC_W'(mag);
        energy_next = (state == RUN) ? sum - oldest : sum;
        if (v2) begin
            case (state)
                FILL: begin
                    if (fill_cnt == WIN_LOG2'(N - 1)) begin
                        emit      = 1'b1;
                        fill_next = '0;
                        if (mode_q) begin
                            acc_next   = sum;
                            state_next = RUN;
                        end else begin
                            acc_next = '0;
                        end
                    end else begin
                        acc_next  = sum;
                        fill_next = fill_cnt + 1'b1;
                    end
                end
                RUN: begin
                    acc_next = energy_next;
                    emit     = 1'b1;
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state      <= FILL;
            acc        <= '0;
            fill_cnt   <= '0;
            wptr       <= '0;
            out_valid  <= 1'b0;
            energy     <= '0;
            detect     <= 1'b0;
            detect_cnt <= '0;
        end else if (clr) begin
            state      <= FILL;
            acc        <= '0;
            fill_cnt   <= '0;
            wptr       <= '0;
            out_valid  <= 1'b0;
            energy     <= '0;
            detect     <= 1'b0;
            detect_cnt <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            fill_cnt  <= fill_next;
            out_valid <= emit;
            if (v2 && mode_q) begin
                wptr <= wptr + 1'b1;
            end
            if (emit) begin
                energy <= energy_next;
                detect <= (energy_next > threshold);
                if ((energy_next > threshold) && (detect_cnt != 8'hFF)) begin
                    detect_cnt <= detect_cnt + 8'd1;
                end
            end
        end
    end

    // Oldest entry sits at the write pointer: it was written exactly N mags ago.
    always_ff @(posedge clk) begin
        if (v2 && mode_q && !clr) begin
            mag_buf[wptr] <= mag;
        end
    end

endmodule

// File: tb/tb_iq_power_detector.sv
// tb/tb_iq_power_detector.sv - scoreboard bench for iq_power_detector (N=4)
module tb_iq_power_detector;

    localparam int DATA_W   = 8;
    localparam int WIN_LOG2 = 2;
    localparam int ACC_W    = 2 * DATA_W + WIN_LOG2;

    logic                     clk = 1'b0;
    logic                     aclr_n;
    logic                     sclr;
    logic                     mode;
    logic                     in_valid;
    logic signed [DATA_W-1:0] datar;
    logic signed [DATA_W-1:0] datai;
    logic [ACC_W-1:0]         threshold;
    logic                     out_valid;
    logic [ACC_W-1:0]         energy;
    logic                     detect;
    logic [7:0]               detect_cnt;

    iq_power_detector #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .sclr       (sclr),
        .mode       (mode),
        .in_valid   (in_valid),
        .datar      (datar),
        .datai      (datai),
        .threshold  (threshold),
        .out_valid  (out_valid),
        .energy     (energy),
        .detect     (detect),
        .detect_cnt (detect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC_W-1:0] energy;
        logic             detect;
        logic [7:0]       cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic push(input int e, input bit d);
        if (d && exp_cnt < 255) exp_cnt++;
        sb.push_back('{energy: ACC_W'(e), detect: d, cnt: 8'(exp_cnt)});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int re, input int im);
        datar    = 8'(re);
        datai    = 8'(im);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic window(input int re, input int im, input int e, input bit d);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(e, d);
            send(re, im);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_energy"}, 32'(energy), 0);
        chk({tag, "_detect"}, 32'(detect), 0);
        chk({tag, "_detect_cnt"}, 32'(detect_cnt), 0);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got energy=%0d want no result", energy);
            end else begin
                mon_e = sb.pop_front();
                chk("energy", 32'(energy), 32'(mon_e.energy));
                chk("detect", 32'(detect), 32'(mon_e.detect));
                chk("detect_cnt", 32'(detect_cnt), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        aclr_n = 1'b0; sclr = 1'b0; mode = 1'b0; in_valid = 1'b0;
        datar = '0; datai = '0; threshold = '0;
        idle(3);
        check_zero("reset");
        aclr_n = 1'b1;
        idle(2);

        threshold = 99;
        window(3, 4, 100, 1);
        idle(5);
        threshold = 100;
        window(3, 4, 100, 0);
        idle(5);

        threshold = 0;
        window(-128, -128, 131072, 1);
        window(0, 0, 0, 0);
        idle(5);

        threshold = 99;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(100, 1);
            send(3, 4);
            idle(1);
        end
        idle(5);

        threshold = 0;
        send(1, 1);
        send(1, 1);
        sclr = 1'b1;
        send(1, 1);
        sclr = 1'b0;
        exp_cnt = 0;
        check_zero("sclr");
        window(1, 1, 8, 1);
        idle(5);

        send(1, 1);
        send(1, 1);
        aclr_n = 1'b0;
        #2;
        check_zero("aclr_now");
        idle(2);
        check_zero("aclr_hold");
        aclr_n = 1'b1;
        exp_cnt = 0;
        idle(2);
        window(1, 1, 8, 1);
        idle(5);

        mode = 1'b1;
        idle(3);
        exp_cnt = 0;
        threshold = 50;
        send(1, 0);
        send(2, 0);
        send(3, 0);
        push(30, 0);
        send(4, 0);
        push(54, 1);
        send(5, 0);
        push(86, 1);
        send(6, 0);
        idle(5);

        mode = 1'b0;
        idle(3);
        exp_cnt = 0;
        threshold = 0;
        send(3, 4);
        send(3, 4);
        mode = 1'b1;
        idle(3);
        exp_cnt = 0;
        window(3, 4, 100, 1);
        idle(5);

        mode = 1'b0;
        idle(3);
        exp_cnt = 0;
        for (int w = 0; w < 300; w++) begin
            window(3, 4, 100, 1);
        end
        idle(6);
        chk("saturated_detect_cnt", 32'(detect_cnt), 255);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
